// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// Optional grant statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SELW  = 3,
  parameter int unsigned CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [SELW-1:0]  req_sel0,
  output logic             req_ready0,
  input  logic             req_valid1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [SELW-1:0]  req_sel1,
  output logic             req_ready1,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNTW-1:0]  grant_cnt0,
  output logic [CNTW-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;
  logic             grant0_c, grant1_c;

  // Winner: sole valid requester, or the rr pointer when both are valid.
  always_comb begin
    grant0_c = (state_q == IDLE) && req_valid0 && (!req_valid1 || !rr_q);
    grant1_c = (state_q == IDLE) && req_valid1 && (!req_valid0 ||  rr_q);
  end

  assign req_ready0 = grant0_c;
  assign req_ready1 = grant1_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      id_q        <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    id_d        = id_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant0_c) begin
          a_d     = req_a0;
          b_d     = req_b0;
          sel_d   = req_sel0;
          id_d    = 1'b0;
          rr_d    = 1'b1;
          state_d = EXEC;
        end else if (grant1_c) begin
          a_d     = req_a1;
          b_d     = req_b1;
          sel_d   = req_sel1;
          id_d    = 1'b1;
          rr_d    = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d      = alu_result;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // No bypass: the next request is only considered back in IDLE.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] cnt0_q, cnt0_d;
  logic [CNTW-1:0] cnt1_q, cnt1_d;

  // Saturating per-requester grant counters; cleared only by reset.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0_c && (cnt0_q != {CNTW{1'b1}})) cnt0_d = cnt0_q + CNTW'(1);
    if (grant1_c && (cnt1_q != {CNTW{1'b1}})) cnt1_d = cnt1_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: bench-side alu model, queued expected
// responses, arbitration-order and statistics models.
module tb_alu_arbiter;

`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid0, req_valid1;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0] req_sel0, req_sel1;
  logic       req_ready0, req_ready1;
  logic       rsp_valid, rsp_id, rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_sel;
  logic       busy;
  logic [7:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];
  logic [4:0] mon_e;
  logic       rr_m = 1'b0;
  int         cnt0_m = 0;
  int         cnt1_m = 0;
  int         bp_mode = 0;
  logic       bp_rand = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
    case (s)
      3'd0:    return 4'(a + b);
      3'd1:    return 4'(a - b);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_sel);
  assign rsp_ready  = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'b0 : bp_rand;

  alu_arbiter #(.WIDTH(4), .SELW(3), .CNTW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid0(req_valid0), .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
    .req_ready0(req_ready0),
    .req_valid1(req_valid1), .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
    .req_ready1(req_ready1),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int m);
    return STATS ? 32'(m) : 32'd0;
  endfunction

  initial forever begin
    @(posedge clk);
    #1 bp_rand = 1'($urandom_range(0, 1));
  end

  // Response monitor: pop and compare on every accepted response.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("ready_excl", 32'(req_ready0 & req_ready1), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(mon_e[3:0]));
          check("rsp_id", 32'(rsp_id), 32'(mon_e[4]));
        end
      end
    end
  end

  task automatic check_idle_outs(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_alu_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnt0"}, 32'(grant_cnt0), 32'd0);
    check({tag, "_cnt1"}, 32'(grant_cnt1), 32'd0);
    check({tag, "_ready"}, 32'({req_ready0, req_ready1}), 32'd0);
  endtask

  // Present up to two requests; expectations are queued in modelled grant order.
  task automatic drive(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic [2:0] s0, input logic v1, input logic [3:0] a1,
                       input logic [3:0] b1, input logic [2:0] s1);
    logic nxt, p0, p1, g0, g1;
    int n;
    nxt = (v0 && v1) ? rr_m : v1;
    if (!nxt) begin
      if (v0) exp_q.push_back({1'b0, ref_alu(a0, b0, s0)});
      if (v1) exp_q.push_back({1'b1, ref_alu(a1, b1, s1)});
    end else begin
      if (v1) exp_q.push_back({1'b1, ref_alu(a1, b1, s1)});
      if (v0) exp_q.push_back({1'b0, ref_alu(a0, b0, s0)});
    end
    @(posedge clk);
    #1;
    req_valid0 = v0; req_a0 = a0; req_b0 = b0; req_sel0 = s0;
    req_valid1 = v1; req_a1 = a1; req_b1 = b1; req_sel1 = s1;
    p0 = v0; p1 = v1; n = 0;
    while ((p0 || p1) && n < 40) begin
      @(negedge clk);
      g0 = req_ready0; g1 = req_ready1;
      @(posedge clk);
      #1;
      if (g0 && p0) begin
        check("grant_id", 32'd0, 32'(nxt));
        nxt = 1'b1; p0 = 1'b0; req_valid0 = 1'b0; rr_m = 1'b1;
        if (cnt0_m != 255) cnt0_m++;
      end
      if (g1 && p1) begin
        check("grant_id", 32'd1, 32'(nxt));
        nxt = 1'b0; p1 = 1'b0; req_valid1 = 1'b0; rr_m = 1'b0;
        if (cnt1_m != 255) cnt1_m++;
      end
      n++;
    end
    if (p0 || p1) begin
      check("grant_timeout", 32'({p0, p1}), 32'd0);
      req_valid0 = 1'b0; req_valid1 = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rr_m = 1'b0; cnt0_m = 0; cnt1_m = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic g;
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_a0 = '0; req_b0 = '0; req_sel0 = '0;
    req_valid1 = 1'b0; req_a1 = '0; req_b1 = '0; req_sel1 = '0;
    repeat (2) @(negedge clk);
    check_idle_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both valid straight after reset: req0 first, then req1.
    drive(1'b1, 4'b0110, 4'b0001, 3'b001, 1'b1, 4'b0110, 4'b0001, 3'b010);
    drain();

    // Single req0 add, with latency and operand checks.
    drive(1'b1, 4'b0110, 4'b0001, 3'b000, 1'b0, 4'd0, 4'd0, 3'd0);
    @(negedge clk);
    check("t1_exec_valid", 32'(rsp_valid), 32'd0);
    check("t1_exec_busy", 32'(busy), 32'd1);
    check("t1_alu_a", 32'(alu_a), 32'h6);
    check("t1_alu_b", 32'(alu_b), 32'h1);
    check("t1_alu_sel", 32'(alu_sel), 32'h0);
    @(negedge clk);
    check("t1_resp_valid", 32'(rsp_valid), 32'd1);
    drain();

    // Wrap-around add and xor on req1.
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b1111, 4'b0001, 3'b000);
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b0110, 4'b0001, 3'b100);
    drain();

    // Backpressure: response held stable, no grants while in RESP.
    bp_mode = 1;
    drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'b0011, 4'b0101, 3'b011);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t3_reach_resp", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_valid", 32'(rsp_valid), 32'd1);
      check("t3_data", 32'(rsp_data), 32'(exp_q[0][3:0]));
      check("t3_id", 32'(rsp_id), 32'(exp_q[0][4]));
      check("t3_ready", 32'({req_ready0, req_ready1}), 32'd0);
      check("t3_busy", 32'(busy), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    bp_mode = 0;
    drain();

    // Reset while EXEC: op discarded, rr pointer back to req0.
    req_valid0 = 1'b1; req_a0 = 4'b0101; req_b0 = 4'b0011; req_sel0 = 3'b000;
    g = 1'b0; n = 0;
    while (!g && n < 20) begin
      @(negedge clk);
      g = req_ready0;
      n++;
    end
    check("t5_grant", 32'(g), 32'd1);
    @(posedge clk);
    #1;
    req_valid0 = 1'b0;
    #2;
    check("t5_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outs("t5_reset");
    rr_m = 1'b0; cnt0_m = 0; cnt1_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    drive(1'b1, 4'b1000, 4'b0011, 3'b001, 1'b1, 4'b1010, 4'b0110, 3'b011);
    drain();

    // Statistics counters.
    do_reset();
    for (int i = 0; i < 3; i++)
      drive(1'b0, 4'd0, 4'd0, 3'd0, 1'b1, 4'(i), 4'd2, 3'b000);
    drain();
    check("t6_cnt1", 32'(grant_cnt1), exp_cnt(cnt1_m));
    check("t6_cnt0", 32'(grant_cnt0), exp_cnt(cnt0_m));
    for (int i = 0; i < 260; i++)
      drive(1'b1, 4'($urandom), 4'($urandom), 3'($urandom), 1'b0, 4'd0, 4'd0, 3'd0);
    drain();
    check("t6_cnt0_sat", 32'(grant_cnt0), exp_cnt(cnt0_m));
    check("t6_cnt1_hold", 32'(grant_cnt1), exp_cnt(cnt1_m));

    // Random mixed traffic with random response backpressure.
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      drive(v0, 4'($urandom), 4'($urandom), 3'($urandom),
            v1, 4'($urandom), 4'($urandom), 3'($urandom));
    end
    bp_mode = 0;
    drain();
    check("rnd_cnt0", 32'(grant_cnt0), exp_cnt(cnt0_m));
    check("rnd_cnt1", 32'(grant_cnt1), exp_cnt(cnt1_m));
    check("rnd_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

endmodule
